memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL be the memory address width.
REQ-002 Parameter DATA_W, default 64, SHALL be the load/store data width.
REQ-003 Parameter PAYLOAD_W, default 256, SHALL be the width of the opaque decoded-instruction bundle carried through the stage.
REQ-004 Parameter TIMEOUT, default 255, minimum 1, SHALL be the maximum number of cycles to wait for a memory response.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  squash in-flight op (pipeline redirect).
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage accepts op.
- in_payload  in  PAYLOAD_W  decoded fields (rip, opcode, operands, regs, imm/disp).
- in_load  in  1  op reads memory.
- in_store  in  1  op writes memory.
- in_addr  in  ADDR_W  memory address.
- in_wdata  in  DATA_W  store data.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_we  out  1  1 = write.
- mem_req_wdata  out  DATA_W  write data.
- mem_resp_valid  in  1  response/ack valid.
- mem_resp_data  in  DATA_W  load data.
- out_valid  out  1  downstream op valid.
- out_ready  in  1  downstream accepts.
- out_payload  out  PAYLOAD_W  registered copy of in_payload.
- out_ldata  out  DATA_W  load result, 0 for non-loads.
- out_fault  out  1  op completed with error.

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT; a single-entry output register SHALL hold out_*.
REQ-007 in_ready SHALL equal (state==IDLE) && !flush && (!out_valid || out_ready).
REQ-008 An accept (in_valid && in_ready) with in_load==0 and in_store==0 SHALL load the output register, with out_valid=1 the next cycle (latency 1), out_ldata=0, and out_fault=0.
REQ-009 An accept with exactly one of in_load or in_store SHALL latch addr, wdata, we(=in_store), and payload, then enter REQ.
REQ-010 In REQ, mem_req_valid SHALL be 1 with addr/we/wdata stable until mem_req_ready; the handshake cycle SHALL move to WAIT.
REQ-011 In WAIT, mem_resp_valid SHALL complete the op: out_valid=1 next cycle, out_ldata=mem_resp_data for loads (0 for stores), out_fault=0, then return to IDLE.
REQ-012 A timeout counter SHALL clear on WAIT entry and increment each WAIT cycle; reaching TIMEOUT without a response SHALL complete the op with out_fault=1 and out_ldata=0, then return to IDLE.
REQ-013 An accept with in_load and in_store both 1 SHALL issue no request and SHALL complete at latency 1 with out_fault=1.
REQ-014 mem_resp_valid in IDLE or REQ SHALL be ignored; a response and a timeout in the same cycle SHALL resolve as a response.
REQ-015 out_* SHALL hold stable while out_valid && !out_ready.
REQ-016 flush SHALL force IDLE, clear out_valid and mem_req_valid next cycle, and take priority over accept and completion in the same cycle.

Reset
REQ-017 On reset: state=IDLE, counter=0, and all outputs 0 (in_ready rises the cycle after reset deasserts); reset mid-REQ/WAIT SHALL abandon the op silently.

Structure
REQ-018 Package memory_stage_pkg SHALL hold the state enum and default parameter constants.
REQ-019 The timeout counter SHALL be sub-module memory_stage_timer (inputs clear/enable, output expired).

Verification
REQ-020 ALU op, payload 0xA5.., out_ready=1 -> out_valid 1 cycle after accept, payload equal, out_ldata=0.
REQ-021 Load addr 0x1000, mem_req_ready low 3 cycles, response data 0xDEADBEEF 2 cycles later -> req held stable 4 cycles, out_ldata=0xDEADBEEF, out_fault=0.
REQ-022 Store addr 0x2000, wdata 0x55, no response, TIMEOUT=4 -> mem_req_we=1, out_fault=1 four WAIT cycles after the handshake.
REQ-023 Load completes with out_ready low 5 cycles -> out_* stable, in_ready=0 throughout.
REQ-024 flush asserted in WAIT, response arrives the next cycle -> no out_valid, response dropped, state IDLE.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types and default sizing for the memory stage and its timeout timer.
package memory_stage_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} stageState;

    localparam int DefAddrW    = 64;
    localparam int DefDataW    = 64;
    localparam int DefPayloadW = 256;
    localparam int DefTimeout  = 255;
endpackage

// File: rtl/memory_stage_timer.sv
// Response timeout counter: cleared on WAIT entry, counts WAIT cycles, flags the TIMEOUT-th one.
module memory_stage_timer
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = DefTimeout
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
    end

    // Expires during the TIMEOUT-th enabled cycle, so completion registers at its end.
    assign expired = enable && (count == CntW'(TIMEOUT - 1));
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: single outstanding load/store with timeout, one-entry output register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W    = DefAddrW,
    parameter int DATA_W    = DefDataW,
    parameter int PAYLOAD_W = DefPayloadW,
    parameter int TIMEOUT   = DefTimeout
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_load,
    input  logic                 in_store,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_wdata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic                 mem_req_we,
    output logic [DATA_W-1:0]    mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [DATA_W-1:0]    mem_resp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [DATA_W-1:0]    out_ldata,
    output logic                 out_fault
);
    stageState state, stateNext;

    logic                 resetDone;
    logic                 accept, isMemOp, doneResp, doneTimeout;
    logic                 timerClear, timerEnable, timerExpired;
    logic [ADDR_W-1:0]    reqAddr;
    logic [DATA_W-1:0]    reqWdata;
    logic                 reqWe;
    logic                 outValid, outFault;
    logic [PAYLOAD_W-1:0] outPayload;
    logic [DATA_W-1:0]    outLdata;

    memory_stage_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        timerClear    = 1'b0;
        timerEnable   = 1'b0;
        doneResp      = 1'b0;
        doneTimeout   = 1'b0;
        isMemOp       = in_load ^ in_store;
        case (state)
            IDLE: begin
                in_ready = resetDone && !flush && (!outValid || out_ready);
                accept   = in_valid && in_ready;
                if (accept && isMemOp) stateNext = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    stateNext  = WAIT;
                    timerClear = 1'b1;
                end
            end
            WAIT: begin
                timerEnable = 1'b1;
                // A response beats a simultaneous timeout.
                if (mem_resp_valid) begin
                    doneResp  = 1'b1;
                    stateNext = IDLE;
                end else if (timerExpired) begin
                    doneTimeout = 1'b1;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (flush) begin
            stateNext   = IDLE;
            doneResp    = 1'b0;
            doneTimeout = 1'b0;
        end
    end

    // The output register is empty for the whole life of a memory op, so the
    // payload can be parked there at accept time.
    always_ff @(posedge clk) begin
        if (reset) begin
            resetDone  <= 1'b0;
            reqAddr    <= '0;
            reqWdata   <= '0;
            reqWe      <= 1'b0;
            outValid   <= 1'b0;
            outFault   <= 1'b0;
            outPayload <= '0;
            outLdata   <= '0;
        end else begin
            resetDone <= 1'b1;
            if (flush) begin
                outValid <= 1'b0;
            end else begin
                if (outValid && out_ready) outValid <= 1'b0;
                if (accept) begin
                    reqAddr    <= in_addr;
                    reqWdata   <= in_wdata;
                    reqWe      <= in_store;
                    outPayload <= in_payload;
                    if (!isMemOp) begin
                        outValid <= 1'b1;
                        outLdata <= '0;
                        outFault <= in_load && in_store;
                    end
                end
                if (doneResp) begin
                    outValid <= 1'b1;
                    outLdata <= reqWe ? '0 : mem_resp_data;
                    outFault <= 1'b0;
                end
                if (doneTimeout) begin
                    outValid <= 1'b1;
                    outLdata <= '0;
                    outFault <= 1'b1;
                end
            end
        end
    end

    assign mem_req_addr  = reqAddr;
    assign mem_req_we    = reqWe;
    assign mem_req_wdata = reqWdata;
    assign out_valid     = outValid;
    assign out_payload   = outPayload;
    assign out_ldata     = outLdata;
    assign out_fault     = outFault;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected results queued at accept, checked on output handshake.
module tb_memory_stage;
    localparam int AW = 64, DW = 64, PW = 256, TO = 4;

    logic          clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic          in_valid = 1'b0, in_ready, in_load = 1'b0, in_store = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_wdata = '0;
    logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          out_valid, out_ready = 1'b1, out_fault;
    logic [PW-1:0] out_payload;
    logic [DW-1:0] out_ldata;

    typedef struct {
        logic [PW-1:0] payload;
        logic [DW-1:0] ldata;
        logic          fault;
    } expT;
    expT expQ[$];

    int checks = 0, failures = 0;

    memory_stage #(.ADDR_W(AW), .DATA_W(DW), .PAYLOAD_W(PW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_load(in_load), .in_store(in_store), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_ldata(out_ldata), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    // Scoreboard: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got output payload=%h ldata=%h fault=%0b, required none",
                         out_payload[31:0], out_ldata, out_fault);
            end else begin
                expT e;
                e = expQ.pop_front();
                if (out_payload !== e.payload || out_ldata !== e.ldata || out_fault !== e.fault) begin
                    failures++;
                    $display("FAIL sb_result: got payload=%h ldata=%h fault=%0b, required payload=%h ldata=%h fault=%0b",
                             out_payload[31:0], out_ldata, out_fault, e.payload[31:0], e.ldata, e.fault);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({in_ready, mem_req_valid, out_valid, out_fault} !== 4'b0 || out_ldata !== '0 || out_payload !== '0) begin
            failures++;
            $display("FAIL reset_outputs: in_ready=%0b req=%0b out_valid=%0b fault=%0b ldata=%h, required all 0",
                     in_ready, mem_req_valid, out_valid, out_fault, out_ldata);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got %0b, required 0", in_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise: got %0b, required 1", in_ready);
        end
        tick();
    endtask

    // ALU op (and the load+store fault case) complete one cycle after accept.
    task automatic test_alu(input logic [PW-1:0] p, input logic ld, input logic st);
        out_ready = 1'b1;
        in_valid = 1'b1; in_payload = p; in_load = ld; in_store = st;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL alu_in_ready: got %0b, required 1", in_ready);
        end
        expQ.push_back('{p, '0, ld && st});
        tick();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL alu_latency: out_valid=%0b mem_req_valid=%0b, required 1 and 0", out_valid, mem_req_valid);
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [PW-1:0] p;
            p = {8{$urandom()}};
            in_valid = 1'b1; in_payload = p;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready[%0d]: got %0b, required 1", i, in_ready);
            end
            expQ.push_back('{p, '0, 1'b0});
            tick();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_load;
        logic [PW-1:0] p;
        p = {4{64'h0123_4567_89AB_CDEF}};
        out_ready = 1'b1; mem_req_ready = 1'b0;
        in_valid = 1'b1; in_load = 1'b1; in_addr = 64'h1000; in_payload = p;
        @(negedge clk);
        expQ.push_back('{p, 64'hDEAD_BEEF, 1'b0});
        tick();
        in_valid = 1'b0; in_load = 1'b0; in_addr = 64'h9999;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready  = (i == 3);
            mem_resp_valid = (i == 1);
            mem_resp_data  = 64'hBAD0;
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000 || mem_req_we !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_req_hold[%0d]: valid=%0b addr=%h we=%0b out_valid=%0b, required 1 1000 0 0",
                         i, mem_req_valid, mem_req_addr, mem_req_we, out_valid);
            end
            tick();
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_req_drop: got %0b, required 0", mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_complete: out_valid=%0b, required 1", out_valid);
        end
        tick();
        drain();
    endtask

    task automatic test_store_timeout;
        logic [PW-1:0] p;
        int n;
        p = {8{32'h5A5A_0001}};
        out_ready = 1'b1; mem_req_ready = 1'b1;
        in_valid = 1'b1; in_store = 1'b1; in_addr = 64'h2000; in_wdata = 64'h55; in_payload = p;
        @(negedge clk);
        expQ.push_back('{p, '0, 1'b1});
        tick();
        in_valid = 1'b0; in_store = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 64'h2000 || mem_req_wdata !== 64'h55) begin
            failures++;
            $display("FAIL store_req: valid=%0b we=%0b addr=%h wdata=%h, required 1 1 2000 55",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            mem_req_ready = 1'b0;
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        // Four silent WAIT cycles, then the faulted result appears.
        checks++;
        if (n !== TO + 1) begin
            failures++;
            $display("FAIL store_timeout_latency: got %0d cycles after handshake, required %0d", n, TO + 1);
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure;
        logic [PW-1:0] p;
        p = {8{32'hC0DE_0042}};
        out_ready = 1'b0; mem_req_ready = 1'b1;
        in_valid = 1'b1; in_load = 1'b1; in_addr = 64'h3000; in_payload = p;
        @(negedge clk);
        expQ.push_back('{p, 64'h1234_5678, 1'b0});
        tick();
        in_valid = 1'b0; in_load = 1'b0; in_payload = '0;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h1234_5678;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_ldata !== 64'h1234_5678 || out_payload !== p || out_fault !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out_valid=%0b ldata=%h fault=%0b in_ready=%0b, required 1 12345678 0 0",
                         i, out_valid, out_ldata, out_fault, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_flush_wait;
        out_ready = 1'b1; mem_req_ready = 1'b1;
        in_valid = 1'b1; in_load = 1'b1; in_addr = 64'h4000; in_payload = {8{32'hF1F1_F1F1}};
        tick();
        in_valid = 1'b0; in_load = 1'b0;
        tick();
        mem_req_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hFEED;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_wait[%0d]: out_valid=%0b in_ready=%0b req=%0b, required 0 1 0",
                         i, out_valid, in_ready, mem_req_valid);
            end
            tick();
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic test_flush_req;
        mem_req_ready = 1'b0;
        in_valid = 1'b1; in_store = 1'b1; in_addr = 64'h5000;
        tick();
        in_valid = 1'b0; in_store = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_req: req=%0b in_ready=%0b, required 0 1", mem_req_valid, in_ready);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu({8{32'hA5A5_A5A5}}, 1'b0, 1'b0);
        test_alu({8{32'h3C3C_0F0F}}, 1'b1, 1'b1);
        test_back_to_back();
        test_load();
        test_store_timeout();
        test_backpressure();
        test_flush_wait();
        test_flush_req();
        test_alu({8{32'h0BAD_F00D}}, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
